// File: rtl/signed_from_magnitude_pkg.sv
// signed_from_magnitude_pkg: shared FSM state type and counter sizing for the serial magnitude-to-signed converter
// Contents: state_t (IDLE, SHIFT, DONE); cnt_width(n) gives a counter that can hold n without wrapping.
package signed_from_magnitude_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/signed_from_magnitude_serial_negate_cell.sv
// serial_negate_cell: one bit of LSB-first serial two's-complement negation
// Ports: bit_in (current magnitude bit), sign (1 = negate), seen_one (a 1 was already passed),
//        bit_out (converted bit), seen_one_next (updated seen-one flag).
module serial_negate_cell (
    input  logic bit_in,
    input  logic sign,
    input  logic seen_one,
    output logic bit_out,
    output logic seen_one_next
);
    // -x copies bits up to and including the first 1, then inverts the rest
    assign bit_out       = bit_in ^ (sign & seen_one);
    assign seen_one_next = seen_one | bit_in;
endmodule

// File: rtl/signed_from_magnitude.sv
// signed_from_magnitude: bit-serial conversion of sign/magnitude to N-bit two's complement with overflow flag
// Ports: clk, reset (sync, active-high); start, magnitude[N-1:0], sign in;
//        busy, done (1-cycle pulse), result[N-1:0], overflow out.
// Option: define SIGNED_FROM_MAGNITUDE_ZERO_BYPASS_EN to skip the shift phase for a zero magnitude.
module signed_from_magnitude
    import signed_from_magnitude_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] magnitude,
    input  logic         sign,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         overflow
);
    localparam int CW = cnt_width(N);
    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   sr;
    logic           sign_q;
    logic           seen_one;
    logic           bit_out;
    logic           seen_one_next;
    logic           last;
    serial_negate_cell u_cell (
        .bit_in        (sr[0]),
        .sign          (sign_q),
        .seen_one      (seen_one),
        .bit_out       (bit_out),
        .seen_one_next (seen_one_next)
    );
    assign busy = state != IDLE;
    assign last = cnt == CW'(N - 1);
    // One register serves both roles: magnitude bits leave at the LSB while converted bits enter at the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            sign_q   <= 1'b0;
            seen_one <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sr       <= magnitude;
                    sign_q   <= sign;
                    cnt      <= '0;
                    seen_one <= 1'b0;
`ifdef SIGNED_FROM_MAGNITUDE_ZERO_BYPASS_EN
                    if (magnitude == '0) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        result   <= '0;
                        overflow <= 1'b0;
                    end else
`endif
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr       <= {bit_out, sr[N-1:1]};
                    seen_one <= seen_one_next;
                    cnt      <= cnt + 1'b1;
                    if (last) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        result   <= {bit_out, sr[N-1:1]};
                        // MSB set overflows unless negating exactly 2^(N-1) (no lower one seen)
                        overflow <= sr[0] & (~sign_q | seen_one);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
